// File: rtl/hba_quad_enc_pkg.sv
// Shared register map, CTRL/STATUS bit positions and the quadrature step decode.
package hba_quad_enc_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'd0;
  localparam logic [7:0] OFF_L_LO   = 8'd1;
  localparam logic [7:0] OFF_L_HI   = 8'd2;
  localparam logic [7:0] OFF_R_LO   = 8'd3;
  localparam logic [7:0] OFF_R_HI   = 8'd4;
  localparam logic [7:0] OFF_STATUS = 8'd5;

  localparam int unsigned CTRL_EN_L = 0;
  localparam int unsigned CTRL_EN_R = 1;
  localparam int unsigned CTRL_IE   = 2;
  localparam int unsigned CTRL_CLR  = 3;

  localparam int unsigned STAT_CHG_L = 0;
  localparam int unsigned STAT_CHG_R = 1;
  localparam int unsigned STAT_ERR_L = 2;
  localparam int unsigned STAT_ERR_R = 3;

  typedef enum logic [1:0] {StepNone, StepUp, StepDown, StepErr} step_e;

  // Encoder sample is {A,B}; A leading B (00->10->11->01) counts up.
  function automatic step_e decode_step(logic [1:0] prev, logic [1:0] cur);
    logic [1:0] diff;
    diff = prev ^ cur;
    case (diff)
      2'b00:   return StepNone;
      2'b11:   return StepErr;
      default: return (prev[0] ^ cur[1]) ? StepUp : StepDown;
    endcase
  endfunction

endpackage

// File: rtl/hba_quad_enc_quad_decoder.sv
// One quadrature channel: 2-flop synchronizer, step decode, 16-bit wrapping counter.
module quad_decoder
  import hba_quad_enc_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_enc,
  input  logic        i_en,
  input  logic        i_clr,
  output logic [15:0] o_count,
  output logic        o_changed,
  output logic        o_err
);

  logic [1:0]  r_sync1, r_sync2, r_prev;
  logic [15:0] r_count, w_count_d;
  step_e       w_step;

  assign w_step = decode_step(r_prev, r_sync2);

  // Synchronizer and previous-sample tracking run regardless of enable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_prev  <= 2'b00;
    end else begin
      r_sync1 <= i_enc;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Next count; clear wins over a coincident step and does not flag a change.
  always_comb begin
    w_count_d = r_count;
    o_changed = 1'b0;
    o_err     = i_en && (w_step == StepErr);
    if (i_clr) begin
      w_count_d = 16'h0000;
    end else if (i_en) begin
      case (w_step)
        StepUp: begin
          w_count_d = r_count + 16'd1;
          o_changed = 1'b1;
        end
        StepDown: begin
          w_count_d = r_count - 16'd1;
          o_changed = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Count register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_count <= 16'h0000;
    else       r_count <= w_count_d;
  end

  assign o_count = r_count;

endmodule

// File: rtl/hba_quad_enc.sv
// HBA slave exposing two quadrature counters with atomic 16-bit reads and a level interrupt.
module hba_quad_enc
  import hba_quad_enc_pkg::*;
#(
  parameter int unsigned DBUS_WIDTH        = 8,
  parameter int unsigned PERIPH_ADDR_WIDTH = 4,
  parameter int unsigned REG_ADDR_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int unsigned PERIPH_ADDR       = 2
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset,
  input  logic                  hba_rnw,
  input  logic                  hba_select,
  input  logic [ADDR_WIDTH-1:0] hba_abus,
  input  logic [DBUS_WIDTH-1:0] hba_dbus,
  output logic [DBUS_WIDTH-1:0] hba_dbus_slave,
  output logic                  hba_xferack_slave,
  input  logic [1:0]            quad_enc_l,
  input  logic [1:0]            quad_enc_r,
  output logic                  quad_intr
);

  logic                      r_ack, r_rnw, r_intr;
  logic [REG_ADDR_WIDTH-1:0] r_off;
  logic [2:0]                r_ctrl;
  logic [3:0]                r_status, w_status_d;
  logic [7:0]                r_shadow_l, r_shadow_r, w_rdata;
  logic [15:0]               w_count_l, w_count_r;
  logic                      w_hit, w_ack_wr, w_ack_rd, w_wr_ctrl, w_clr;
  logic                      w_chg_l, w_chg_r, w_err_l, w_err_r;
  logic                      w_unused;

  assign w_hit = hba_select && !r_ack &&
                 (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));
  assign w_ack_wr  = r_ack && !r_rnw;
  assign w_ack_rd  = r_ack && r_rnw;
  assign w_wr_ctrl = w_ack_wr && (r_off == REG_ADDR_WIDTH'(OFF_CTRL));
  assign w_clr     = w_wr_ctrl && hba_dbus[CTRL_CLR];
  assign w_unused  = ^hba_dbus[DBUS_WIDTH-1:4];

  quad_decoder u_dec_l (
    .i_clk     (hba_clk),
    .i_rst     (hba_reset),
    .i_enc     (quad_enc_l),
    .i_en      (r_ctrl[CTRL_EN_L]),
    .i_clr     (w_clr),
    .o_count   (w_count_l),
    .o_changed (w_chg_l),
    .o_err     (w_err_l)
  );

  quad_decoder u_dec_r (
    .i_clk     (hba_clk),
    .i_rst     (hba_reset),
    .i_enc     (quad_enc_r),
    .i_en      (r_ctrl[CTRL_EN_R]),
    .i_clr     (w_clr),
    .o_count   (w_count_r),
    .o_changed (w_chg_r),
    .o_err     (w_err_r)
  );

  // Bus handshake: ack exactly one cycle after a hit, capturing direction and offset.
  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      r_ack <= 1'b0;
      r_rnw <= 1'b0;
      r_off <= '0;
    end else begin
      r_ack <= w_hit;
      if (w_hit) begin
        r_rnw <= hba_rnw;
        r_off <= hba_abus[REG_ADDR_WIDTH-1:0];
      end
    end
  end

  // Read data mux; unmapped offsets read as zero.
  always_comb begin
    w_rdata = 8'h00;
    case (r_off)
      REG_ADDR_WIDTH'(OFF_CTRL):   w_rdata = {5'b0, r_ctrl};
      REG_ADDR_WIDTH'(OFF_L_LO):   w_rdata = w_count_l[7:0];
      REG_ADDR_WIDTH'(OFF_L_HI):   w_rdata = r_shadow_l;
      REG_ADDR_WIDTH'(OFF_R_LO):   w_rdata = w_count_r[7:0];
      REG_ADDR_WIDTH'(OFF_R_HI):   w_rdata = r_shadow_r;
      REG_ADDR_WIDTH'(OFF_STATUS): w_rdata = {4'b0, r_status};
      default:                     w_rdata = 8'h00;
    endcase
  end

  assign hba_dbus_slave    = w_ack_rd ? DBUS_WIDTH'(w_rdata) : '0;
  assign hba_xferack_slave = r_ack;

  // STATUS next state: a read clears, new events set, set wins.
  always_comb begin
    w_status_d = r_status;
    if (w_ack_rd && (r_off == REG_ADDR_WIDTH'(OFF_STATUS))) w_status_d = 4'b0000;
    w_status_d[STAT_CHG_L] = w_status_d[STAT_CHG_L] | w_chg_l;
    w_status_d[STAT_CHG_R] = w_status_d[STAT_CHG_R] | w_chg_r;
    w_status_d[STAT_ERR_L] = w_status_d[STAT_ERR_L] | w_err_l;
    w_status_d[STAT_ERR_R] = w_status_d[STAT_ERR_R] | w_err_r;
  end

  // CTRL, shadows, STATUS and registered interrupt.
  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      r_ctrl     <= 3'b000;
      r_shadow_l <= 8'h00;
      r_shadow_r <= 8'h00;
      r_status   <= 4'b0000;
      r_intr     <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= hba_dbus[2:0];
      if (w_ack_rd && (r_off == REG_ADDR_WIDTH'(OFF_L_LO))) r_shadow_l <= w_count_l[15:8];
      if (w_ack_rd && (r_off == REG_ADDR_WIDTH'(OFF_R_LO))) r_shadow_r <= w_count_r[15:8];
      r_status <= w_status_d;
      r_intr   <= r_ctrl[CTRL_IE] && (r_status != 4'b0000);
    end
  end

  assign quad_intr = r_intr;

endmodule

// File: tb/tb_hba_quad_enc.sv
// Directed bench for hba_quad_enc: bus reads/writes, encoder steps, shadow, status, interrupt.
module tb_hba_quad_enc;

  logic        hba_clk = 1'b0;
  logic        hba_reset;
  logic        hba_rnw;
  logic        hba_select;
  logic [11:0] hba_abus;
  logic [7:0]  hba_dbus;
  logic [7:0]  hba_dbus_slave;
  logic        hba_xferack_slave;
  logic [1:0]  enc_l, enc_r;
  logic        quad_intr;

  int n_tests = 0;
  int n_fail  = 0;

  hba_quad_enc dut (
    .hba_clk           (hba_clk),
    .hba_reset         (hba_reset),
    .hba_rnw           (hba_rnw),
    .hba_select        (hba_select),
    .hba_abus          (hba_abus),
    .hba_dbus          (hba_dbus),
    .hba_dbus_slave    (hba_dbus_slave),
    .hba_xferack_slave (hba_xferack_slave),
    .quad_enc_l        (enc_l),
    .quad_enc_r        (enc_r),
    .quad_intr         (quad_intr)
  );

  always #5 hba_clk = ~hba_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Gray sequence for A leading B.
  function automatic logic [1:0] fwd(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Called just after a clock edge; returns just after the edge that ends the ack cycle.
  task automatic bus(input logic rnw, input logic [7:0] off, input logic [7:0] wd,
                     output logic [7:0] rd);
    hba_select = 1'b1;
    hba_rnw    = rnw;
    hba_abus   = {4'd2, off};
    hba_dbus   = wd;
    @(posedge hba_clk); #1;
    check("ack_rise", {15'b0, hba_xferack_slave}, 16'h1);
    rd = hba_dbus_slave;
    @(posedge hba_clk); #1;
    hba_select = 1'b0;
    check("ack_fall", {15'b0, hba_xferack_slave}, 16'h0);
    check("dbus_idle", {8'b0, hba_dbus_slave}, 16'h0);
  endtask

  task automatic rd(input string tag, input logic [7:0] off, input logic [7:0] exp);
    logic [7:0] d;
    bus(1'b1, off, 8'h00, d);
    check(tag, {8'b0, d}, {8'b0, exp});
  endtask

  task automatic wr(input logic [7:0] off, input logic [7:0] data);
    logic [7:0] d;
    bus(1'b0, off, data, d);
  endtask

  // Input change reaches the count on the third edge.
  task automatic step_l(input logic up);
    enc_l = up ? fwd(enc_l) : rev(enc_l);
    repeat (3) @(posedge hba_clk);
    #1;
  endtask

  task automatic step_r(input logic up);
    enc_r = up ? fwd(enc_r) : rev(enc_r);
    repeat (3) @(posedge hba_clk);
    #1;
  endtask

  initial begin
    hba_reset  = 1'b1;
    hba_rnw    = 1'b0;
    hba_select = 1'b0;
    hba_abus   = '0;
    hba_dbus   = '0;
    enc_l      = 2'b00;
    enc_r      = 2'b00;
    repeat (2) @(posedge hba_clk);
    #1;
    check("rst_ack", {15'b0, hba_xferack_slave}, 16'h0);
    check("rst_intr", {15'b0, quad_intr}, 16'h0);
    hba_reset = 1'b0;
    @(posedge hba_clk); #1;

    // Reset values
    rd("rst_ctrl", 8'd0, 8'h00);
    rd("rst_l_lo", 8'd1, 8'h00);
    rd("rst_status", 8'd5, 8'h00);
    check("rst_intr2", {15'b0, quad_intr}, 16'h0);

    // Five forward left steps
    wr(8'd0, 8'h01);
    for (int i = 0; i < 5; i++) step_l(1'b1);
    rd("fwd5_lo", 8'd1, 8'h05);
    rd("fwd5_hi", 8'd2, 8'h00);

    // Clear then one reverse step wraps to 0xFFFF
    wr(8'd0, 8'h09);
    rd("clr_ctrl", 8'd0, 8'h01);
    step_l(1'b0);
    rd("wrap_lo", 8'd1, 8'hFF);
    rd("wrap_hi", 8'd2, 8'hFF);

    // Shadow holds the high byte across a carry
    wr(8'd0, 8'h09);
    for (int i = 0; i < 255; i++) step_l(1'b1);
    rd("shd_lo", 8'd1, 8'hFF);
    step_l(1'b1);
    rd("shd_hi", 8'd2, 8'h00);
    rd("shd_lo2", 8'd1, 8'h00);
    rd("shd_hi2", 8'd2, 8'h01);

    // Unmapped offset and foreign slot
    rd("unmapped", 8'd6, 8'h00);
    wr(8'd7, 8'h5A);
    rd("ctrl_kept", 8'd0, 8'h01);
    hba_select = 1'b1;
    hba_rnw    = 1'b1;
    hba_abus   = {4'd3, 8'd0};
    repeat (3) @(posedge hba_clk);
    #1;
    check("foreign_noack", {15'b0, hba_xferack_slave}, 16'h0);
    hba_select = 1'b0;

    // Interrupt from a right step
    wr(8'd0, 8'h07);
    rd("stat_old", 8'd5, 8'h01);
    @(posedge hba_clk); #1;
    check("intr_low", {15'b0, quad_intr}, 16'h0);
    step_r(1'b1);
    @(posedge hba_clk); #1;
    check("intr_high", {15'b0, quad_intr}, 16'h1);
    rd("stat_r", 8'd5, 8'h02);
    @(posedge hba_clk); #1;
    check("intr_cleared", {15'b0, quad_intr}, 16'h0);
    rd("r_lo", 8'd3, 8'h01);
    rd("r_hi", 8'd4, 8'h00);

    // Clear priority over a coincident step, then a double change
    wr(8'd0, 8'h00);
    while (enc_l != 2'b01) step_l(1'b1);
    rd("stat_dis", 8'd5, 8'h00);
    wr(8'd0, 8'h01);
    enc_l = fwd(enc_l);
    @(posedge hba_clk); #1;
    wr(8'd0, 8'h0B);
    rd("clrp_ctrl", 8'd0, 8'h03);
    rd("clrp_lo", 8'd1, 8'h00);
    rd("clrp_hi", 8'd2, 8'h00);
    enc_l = 2'b11;
    repeat (3) @(posedge hba_clk);
    #1;
    rd("dbl_status", 8'd5, 8'h04);
    rd("dbl_lo", 8'd1, 8'h00);

    // Reset during a transfer leaves no ack behind
    hba_select = 1'b1;
    hba_rnw    = 1'b1;
    hba_abus   = {4'd2, 8'd0};
    hba_reset  = 1'b1;
    @(posedge hba_clk); #1;
    check("midrst_ack", {15'b0, hba_xferack_slave}, 16'h0);
    hba_select = 1'b0;
    hba_reset  = 1'b0;
    repeat (2) @(posedge hba_clk);
    #1;
    check("midrst_noack", {15'b0, hba_xferack_slave}, 16'h0);
    rd("midrst_ctrl", 8'd0, 8'h00);
    rd("midrst_lo", 8'd1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
